// File: rtl/wb_msg_pkg.sv
// Shared types and constants for the Wishbone message buffer.
package wb_msg_pkg;

  localparam int WB_DW         = 32;
  localparam int DEFAULT_DEPTH = 8;

  // Write-side handshake with the Wishbone control block.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_PUSH = 2'd1,
    W_DONE = 2'd2
  } wr_state_e;

endpackage : wb_msg_pkg

// File: rtl/wb_msg_buffer_if.sv
// Signals between the Wishbone slave control block and the message buffer.
// The master modport is the control-block/bus side; the slave modport is
// the buffer.
interface wb_msg_buffer_if;
  import wb_msg_pkg::*;

  logic             wbs_req_i;        // stb & cyc from the bus
  logic             wbs_we_i;         // bus write enable
  logic             wbs_ack_i;        // tap of the control block's ack
  logic             input_ready;      // write request active
  logic [WB_DW-1:0] wishbone_data;    // latched write word
  logic             output_ready;     // permits the control block to ack
  logic [WB_DW-1:0] wishbone_output;  // response word for reads

  modport master (
    output wbs_req_i, wbs_we_i, wbs_ack_i, input_ready, wishbone_data,
    input  output_ready, wishbone_output
  );

  modport slave (
    input  wbs_req_i, wbs_we_i, wbs_ack_i, input_ready, wishbone_data,
    output output_ready, wishbone_output
  );

endinterface : wb_msg_buffer_if

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// Full/empty come from the registered count, so a same-cycle pop never
// frees space for a push.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr_q];
  assign count     = count_q;

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count need a known
  // value, and leaving it out keeps the array mappable onto plain RAM.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/wb_msg_buffer.sv
// Wishbone message buffer: each bus write becomes one command word in a
// FIFO for the enclave core; one core response word is held for bus reads.
// output_ready throttles the control block so the host stalls instead of
// losing data.
module wb_msg_buffer
  import wb_msg_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_msg_buffer_if.slave   bus,
  output logic             cmd_valid_o,
  output logic [WB_DW-1:0] cmd_data_o,
  input  logic             cmd_ready_i,
  input  logic             rsp_valid_i,
  input  logic [WB_DW-1:0] rsp_data_i,
  output logic             rsp_ready_o,
  output logic [AW:0]      cmd_count_o
);

  wr_state_e        state_q;
  wr_state_e        state_d;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             res_valid_q;
  logic [WB_DW-1:0] res_data_q;
  logic             rsp_fire;
  logic             rd_ack;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_DW)
  ) u_cmd_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (push),
    .push_data (bus.wishbone_data),
    .pop       (pop),
    .head_data (cmd_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (cmd_count_o)
  );

  assign cmd_valid_o = ~fifo_empty;
  assign pop         = cmd_valid_o & cmd_ready_i;

  // Write FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Write FSM next state and push strobe; exactly one push per transaction.
  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.input_ready) state_d = W_PUSH;
      end
      W_PUSH: begin
        if (!bus.input_ready) begin
          state_d = IDLE;
        end else if (!fifo_full) begin
          push    = 1'b1;
          state_d = W_DONE;
        end
      end
      W_DONE: begin
        if (!bus.input_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes ack once the push is done; reads ack only while the request is
  // still up and a response is pending, which also masks the stale cycle
  // after the request drops.
  assign bus.output_ready = bus.input_ready ? (state_q == W_DONE)
                                            : (bus.wbs_req_i & ~bus.wbs_we_i & res_valid_q);

  assign rsp_ready_o         = ~res_valid_q;
  assign rsp_fire            = rsp_valid_i & rsp_ready_o;
  assign rd_ack              = bus.wbs_ack_i & bus.wbs_req_i & ~bus.wbs_we_i;
  assign bus.wishbone_output = res_data_q;

  // One-entry response register; data only changes while empty, so it is
  // stable through the read ack cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if (rsp_fire) begin
      res_valid_q <= 1'b1;
      res_data_q  <= rsp_data_i;
    end else if (rd_ack) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule : wb_msg_buffer

// File: tb/tb_wb_msg_buffer.sv
// Self-checking bench for wb_msg_buffer. The bench plays the bus master,
// the control block (registered ack) and the core. Pops are scored against
// a queue of written words.
module tb_wb_msg_buffer;
  import wb_msg_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXW  = 64;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             cmd_valid_o;
  logic [WB_DW-1:0] cmd_data_o;
  logic             cmd_ready_i;
  logic             rsp_valid_i;
  logic [WB_DW-1:0] rsp_data_i;
  logic             rsp_ready_o;
  logic [AW:0]      cmd_count_o;
  logic             ack_q;

  wb_msg_buffer_if bus ();

  wb_msg_buffer #(.DEPTH(DEPTH)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .bus         (bus),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_ready_i (cmd_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .rsp_ready_o (rsp_ready_o),
    .cmd_count_o (cmd_count_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Control-block model: write request follows the bus, ack is registered.
  assign bus.input_ready = bus.wbs_req_i & bus.wbs_we_i;
  assign bus.wbs_ack_i   = ack_q;
  always @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) ack_q <= 1'b0;
    else           ack_q <= bus.wbs_req_i & bus.output_ready & ~ack_q;
  end

  int               n_checks = 0;
  int               n_pass   = 0;
  int               n_pushed = 0;
  int               n_popped = 0;
  bit               rand_rdy = 1'b0;
  logic [WB_DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Scoreboard: every word the core takes must be the oldest unconsumed write.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i === 1'b1 && cmd_valid_o === 1'b1 && cmd_ready_i === 1'b1) begin
      n_popped++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got 0x%08h, want no pop", cmd_data_o);
      end else begin
        check("pop_order", cmd_data_o, exp_q.pop_front());
      end
    end
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    if (rand_rdy) cmd_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack_and_release();
    bit got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge wb_clk_i);
      if (ack_q === 1'b1) begin got = 1'b1; break; end
    end
    check("ack_seen", 32'(got), 32'd1);
    tick();
    bus.wbs_req_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    tick();
  endtask

  // Full write transaction; lat = cycles from request to output_ready.
  task automatic do_write(input logic [31:0] d, output int lat);
    bus.wishbone_data = d;
    bus.wbs_we_i      = 1'b1;
    bus.wbs_req_i     = 1'b1;
    exp_q.push_back(d);
    n_pushed++;
    lat = -1;
    for (int c = 0; c < MAXW; c++) begin
      @(negedge wb_clk_i);
      if (bus.output_ready === 1'b1) begin lat = c; break; end
      tick();
    end
    wait_ack_and_release();
  endtask

  task automatic do_read(output logic [31:0] data, output bit ok);
    bus.wbs_we_i  = 1'b0;
    bus.wbs_req_i = 1'b1;
    ok   = 1'b0;
    data = '0;
    for (int c = 0; c < MAXW; c++) begin
      @(negedge wb_clk_i);
      if (ack_q === 1'b1) begin ok = 1'b1; data = bus.wishbone_output; break; end
      tick();
    end
    tick();
    bus.wbs_req_i = 1'b0;
    tick();
  endtask

  task automatic offer_rsp(input logic [31:0] d);
    bit took = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_data_i  = d;
    for (int c = 0; c < 8; c++) begin
      @(negedge wb_clk_i);
      took = (rsp_ready_o === 1'b1);
      tick();
      if (took) break;
    end
    rsp_valid_i = 1'b0;
    check("rsp_taken", 32'(took), 32'd1);
  endtask

  task automatic drain(input int cycles);
    cmd_ready_i = 1'b1;
    repeat (cycles) tick();
    cmd_ready_i = 1'b0;
    @(negedge wb_clk_i);
    check("drain_count", 32'(cmd_count_o), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_head;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          lat;
    int          pops_before;
    logic [31:0] rd;
    logic [31:0] rnd;
    bit          ok;

    tbl[0] = '{1'b1, 32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 32'h11111111, 2, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h22222222, 3, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0,        2, 1'b1, 32'h11111111};
    tbl[4] = '{1'b1, 32'h33333333, 3, 1'b1, 32'h11111111};
    tbl[5] = '{1'b0, 32'h0,        2, 1'b1, 32'h22222222};
    tbl[6] = '{1'b0, 32'h0,        1, 1'b1, 32'h33333333};
    tbl[7] = '{1'b0, 32'h0,        0, 1'b0, 32'h0};

    wb_rst_i          = 1'b0;
    bus.wbs_req_i     = 1'b0;
    bus.wbs_we_i      = 1'b0;
    bus.wishbone_data = '0;
    cmd_ready_i       = 1'b0;
    rsp_valid_i       = 1'b0;
    rsp_data_i        = '0;

    // Reset state.
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_output_ready", 32'(bus.output_ready), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_rsp_ready", 32'(rsp_ready_o), 32'd1);
    check("rst_wishbone_output", bus.wishbone_output, 32'd0);
    check("rst_count", 32'(cmd_count_o), 32'd0);
    tick();
    wb_rst_i = 1'b1;
    tick();

    // Table-driven writes and single pops with the core otherwise stalled.
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].data, lat);
        check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
      end else begin
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
      end
      @(negedge wb_clk_i);
      check($sformatf("tbl%0d_count", i), 32'(cmd_count_o), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_valid", i), 32'(cmd_valid_o), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_head", i), cmd_data_o, tbl[i].exp_head);
      tick();
    end

    // Push and pop in the same cycle at count 3.
    for (int i = 0; i < 3; i++) do_write(32'hA0 + 32'(i), lat);
    bus.wishbone_data = 32'hA3;
    bus.wbs_we_i      = 1'b1;
    bus.wbs_req_i     = 1'b1;
    exp_q.push_back(32'hA3);
    n_pushed++;
    tick();
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    @(negedge wb_clk_i);
    check("pushpop_count", 32'(cmd_count_o), 32'd3);
    check("pushpop_output_ready", 32'(bus.output_ready), 32'd1);
    check("pushpop_head", cmd_data_o, 32'hA1);
    wait_ack_and_release();
    drain(6);

    // Fill to DEPTH, then a write that must stall until one pop.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(32'h100 + 32'(i), lat);
      check("fill_latency", 32'(lat), 32'd2);
    end
    bus.wishbone_data = 32'h1FF;
    bus.wbs_we_i      = 1'b1;
    bus.wbs_req_i     = 1'b1;
    exp_q.push_back(32'h1FF);
    n_pushed++;
    for (int c = 0; c < 4; c++) begin
      @(negedge wb_clk_i);
      check("full_stall_output_ready", 32'(bus.output_ready), 32'd0);
      check("full_stall_count", 32'(cmd_count_o), 32'(DEPTH));
      tick();
    end
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    @(negedge wb_clk_i);
    check("full_after_pop_output_ready", 32'(bus.output_ready), 32'd0);
    check("full_after_pop_count", 32'(cmd_count_o), 32'(DEPTH - 1));
    tick();
    @(negedge wb_clk_i);
    check("full_late_output_ready", 32'(bus.output_ready), 32'd1);
    check("full_late_count", 32'(cmd_count_o), 32'(DEPTH));
    wait_ack_and_release();
    drain(DEPTH + 4);

    // Pointer wrap-around with the core always ready.
    pops_before = n_popped;
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_write(32'(i), lat);
      check("wrap_latency", 32'(lat), 32'd2);
    end
    drain(4);
    check("wrap_pop_total", 32'(n_popped - pops_before), 32'd20);

    // Read with no response pending stalls until the core supplies one.
    bus.wbs_we_i  = 1'b0;
    bus.wbs_req_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk_i);
      check("rd_wait_output_ready", 32'(bus.output_ready), 32'd0);
      check("rd_wait_ack", 32'(ack_q), 32'd0);
      tick();
    end
    rsp_valid_i = 1'b1;
    rsp_data_i  = 32'h12345678;
    @(negedge wb_clk_i);
    check("rsp_ready_before", 32'(rsp_ready_o), 32'd1);
    tick();
    rsp_valid_i = 1'b0;
    @(negedge wb_clk_i);
    check("rd_eligible", 32'(bus.output_ready), 32'd1);
    check("rsp_ready_pending", 32'(rsp_ready_o), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge wb_clk_i);
      if (ack_q === 1'b1) begin ok = 1'b1; break; end
    end
    check("rd_ack_seen", 32'(ok), 32'd1);
    check("rd_data", bus.wishbone_output, 32'h12345678);
    check("rd_rsp_ready_in_ack", 32'(rsp_ready_o), 32'd0);
    tick();
    bus.wbs_req_i = 1'b0;
    rsp_valid_i   = 1'b1;
    rsp_data_i    = 32'hCAFEF00D;
    @(negedge wb_clk_i);
    check("rsp_ready_reassert", 32'(rsp_ready_o), 32'd1);
    tick();
    rsp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk_i);
      check("stale_no_ack", 32'(ack_q), 32'd0);
      check("stale_rsp_held", 32'(rsp_ready_o), 32'd0);
      tick();
    end
    do_read(rd, ok);
    check("rd2_ok", 32'(ok), 32'd1);
    check("rd2_data", rd, 32'hCAFEF00D);

    // Randomized mix of writes and reads with a randomly stalling core.
    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      rnd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        offer_rsp(rnd);
        do_read(rd, ok);
        check("rnd_rd_ok", 32'(ok), 32'd1);
        check("rnd_rd_data", rd, rnd);
      end else begin
        do_write(rnd, lat);
        check("rnd_wr_done", 32'(lat >= 2), 32'd1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    drain(DEPTH + 4);
    check("total_pops", 32'(n_popped), 32'(n_pushed));

    // Reset in W_PUSH with 5 entries and a pending response.
    offer_rsp(32'h55AA55AA);
    for (int i = 0; i < 5; i++) do_write(32'h200 + 32'(i), lat);
    bus.wishbone_data = 32'h2FF;
    bus.wbs_we_i      = 1'b1;
    bus.wbs_req_i     = 1'b1;
    tick();
    #1;
    wb_rst_i = 1'b0;
    #1;
    check("midrst_count", 32'(cmd_count_o), 32'd0);
    check("midrst_output_ready", 32'(bus.output_ready), 32'd0);
    check("midrst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("midrst_rsp_ready", 32'(rsp_ready_o), 32'd1);
    check("midrst_wishbone_output", bus.wishbone_output, 32'd0);
    bus.wbs_req_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    exp_q.delete();
    tick();
    wb_rst_i = 1'b1;
    tick();
    do_write(32'hBEEF0001, lat);
    check("postrst_latency", 32'(lat), 32'd2);
    @(negedge wb_clk_i);
    check("postrst_count", 32'(cmd_count_o), 32'd1);
    check("postrst_head", cmd_data_o, 32'hBEEF0001);
    tick();
    drain(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_msg_buffer
